mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage. Non-memory results pass through with
//   one cycle of latency. Loads and stores are captured, issued to the
//   data memory from the REQ state, and return a single writeback beat.
//   A request that sees no dmem_ready for TIMEOUT cycles is abandoned
//   and reported with a timeout_err pulse.
//
//   Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned
//   halfword/word accesses. A trapped access issues no memory request
//   and reports a misalign pulse. Without the macro, misalign is tied
//   low, halfword accesses use addr[1] only and word accesses ignore
//   addr[1:0].
//
// Parameters
//   TIMEOUT        REQ cycles to wait for dmem_ready before giving up
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       execute-stage result valid
//   opcode, func3  instruction opcode and width/sign select
//   alu_result     ALU result; effective address for load/store
//   store_data     rs2 value for stores
//   rd_in          destination register
//   reg_write_in   writeback enable
//   stall          upstream must hold its inputs
//   dmem_req       memory request
//   dmem_we        write request
//   dmem_addr      word-aligned memory address
//   dmem_wdata     lane-replicated store data
//   dmem_be        byte enables
//   dmem_ready     request accepted/completed
//   dmem_rdata     read word
//   out_valid      writeback payload valid
//   out_result     writeback data
//   rd_out         destination register
//   reg_write_out  writeback enable
//   timeout_err    one-cycle timeout pulse
//   misalign       one-cycle misalignment pulse
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        timeout_err,
  output logic        misalign
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Byte enables for a request. Loads always fetch the full word and
  // pick the lane on return.
  function automatic logic [3:0] byte_en(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
    if (!is_store) return 4'b1111;
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in, so
  // the byte enables alone pick the destination bytes.
  function automatic logic [31:0] lane_rep(input logic [2:0]  f3,
                                           input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed lane of the read word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    b  = 8'(word >> {off, 3'b000});
    h  = 16'(word >> {off[1], 4'b0000});
    sb = signed'(b);
    sh = signed'(h);
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    case (f3)
      3'b001, 3'b101: return off[0];
      3'b010:         return off != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_p0;
  logic [31:0]       addr_p0;
  logic [2:0]        func3_p0;
  logic [31:0]       wdata_p0;
  logic [3:0]        be_p0;
  logic [4:0]        rd_p0;
  logic              store_p0;

  logic              is_mem;
  logic              is_store;
  logic              trap;
  logic              accept_mem;
  logic              done;
  logic              tmo;

  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (state_q == IDLE) && in_valid && is_mem &&
                is_misaligned(func3, alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Next-state: dmem_ready takes priority over the timeout, so a reply in
  // the last allowed cycle still completes normally.
  always_comb begin
    state_d    = state_q;
    accept_mem = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && is_mem && !trap) begin
          state_d    = REQ;
          accept_mem = 1'b1;
        end
      end
      REQ: begin
        if (dmem_ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (cnt_p0 == CNT_LAST) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: captured request and writeback outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_p0        <= '0;
      addr_p0       <= '0;
      func3_p0      <= '0;
      wdata_p0      <= '0;
      be_p0         <= '0;
      rd_p0         <= '0;
      store_p0      <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      timeout_err   <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      misalign    <= 1'b0;

      if (accept_mem) begin
        cnt_p0   <= '0;
        addr_p0  <= alu_result;
        func3_p0 <= func3;
        wdata_p0 <= is_store ? lane_rep(func3, store_data) : 32'd0;
        be_p0    <= byte_en(is_store, func3, alu_result[1:0]);
        rd_p0    <= rd_in;
        store_p0 <= is_store;
      end else if (state_q == REQ) begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end

      if (state_q == IDLE && in_valid && !is_mem) begin
        out_valid     <= 1'b1;
        out_result    <= alu_result;
        rd_out        <= rd_in;
        reg_write_out <= reg_write_in;
      end

      if (trap) begin
        out_valid     <= 1'b1;
        out_result    <= '0;
        rd_out        <= rd_in;
        reg_write_out <= 1'b0;
        misalign      <= 1'b1;
      end

      if (done) begin
        out_valid     <= 1'b1;
        out_result    <= store_p0 ? 32'd0 :
                         load_ext(func3_p0, addr_p0[1:0], dmem_rdata);
        rd_out        <= rd_p0;
        reg_write_out <= !store_p0;
      end

      if (tmo) begin
        out_valid     <= 1'b1;
        out_result    <= '0;
        rd_out        <= rd_p0;
        reg_write_out <= 1'b0;
        timeout_err   <= 1'b1;
      end
    end
  end

  // Memory bus is driven only while a request is outstanding and stays
  // stable for its whole duration because it comes from captured state.
  assign stall      = (state_q == REQ);
  assign dmem_req   = stall;
  assign dmem_we    = stall && store_p0;
  assign dmem_addr  = stall ? {addr_p0[31:2], 2'b00} : 32'd0;
  assign dmem_be    = stall ? be_p0 : 4'd0;
  assign dmem_wdata = stall ? wdata_p0 : 32'd0;

endmodule
